// File: rtl/rv_idu_pkg.sv
// Shared decode definitions for the pipelined IDU: opcodes, ALU and branch
// encodings, memory access sizes and the registered control bundle.
package rv_idu_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  localparam logic [1:0] MEM_SIZE_D = 2'b11;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS_B, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_e;

  // Control fields carried from decode into the ID/EX register.
  typedef struct packed {
    logic       rd_we;
    alu_op_e    alu_op;
    logic       src1_pc;
    logic       src2_imm;
    logic       word;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       mem_uns;
    br_e        br;
    logic       jal;
    logic       jalr;
    logic       ebreak;
    logic       illegal;
  } dec_ctl_t;

  // Branch condition from funct3; BR_NONE marks the two reserved encodings.
  function automatic br_e br_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return BR_EQ;
      3'b001:  return BR_NE;
      3'b100:  return BR_LT;
      3'b101:  return BR_GE;
      3'b110:  return BR_LTU;
      3'b111:  return BR_GEU;
      default: return BR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rv_idu_scoreboard.sv
// Register busy vector: one bit per architectural register with a pending
// writeback. x0 is never marked busy.
module rv_idu_scoreboard
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       busy1,
  output logic       busy2
);

  logic [31:0] busy_q;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // One-hot set/clear masks from the issue and writeback ports.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
  end

  // Busy update: clear first, then set, so a same-cycle set on rd wins.
  // NOTE: state is reset explicitly; a stale busy bit would deadlock issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'h1;
  end

  assign busy1 = busy_q[rs1];
  assign busy2 = busy_q[rs2];

endmodule

// File: rtl/rv_idu_pipe.sv
// Pipelined decode stage: one-entry ID latch, combinational decode with RAW
// interlock against the scoreboard, registered ID/EX output.
module rv_idu_pipe
  import rv_idu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          HAS_M = 1'b1
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output alu_op_e         out_alu_op,
  output logic            out_src1_pc,
  output logic            out_src2_imm,
  output logic            out_word,
  output logic            out_mem_re,
  output logic            out_mem_we,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_uns,
  output br_e             out_br,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_ebreak,
  output logic            out_illegal
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_inst;
  logic            in_fire, id_adv, issue, hazard, busy1, busy2;
  logic            uses_rs1, uses_rs2, legal, shamt_ok;
  dec_ctl_t        ctl, ctl_q;
  logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;

  assign opcode = id_inst[6:0];
  assign f3     = id_inst[14:12];
  assign f7     = id_inst[31:25];

  assign rf_raddr1 = id_inst[19:15];
  assign rf_raddr2 = id_inst[24:20];

  assign hazard   = (uses_rs1 & busy1) | (uses_rs2 & busy2);
  assign id_adv   = id_valid & !hazard & (!out_valid | out_ready);
  assign in_ready = !id_valid | id_adv;
  assign in_fire  = in_valid & in_ready;
  // A flush kills the instruction moving into ID/EX, so it must not set busy.
  assign issue    = id_adv & !flush;

  // On RV32 a shift amount with bit 5 set is reserved.
  assign shamt_ok = IS_RV64 || !id_inst[25];

  assign imm_i = XLEN'($signed(id_inst[31:20]));
  assign imm_s = XLEN'($signed({id_inst[31:25], id_inst[11:7]}));
  assign imm_b = XLEN'($signed({id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({id_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({id_inst[31], id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0}));

  // ID latch: load on accept, drain on issue, drop on flush.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else begin
      if (flush)        id_valid <= 1'b0;
      else if (in_fire) id_valid <= 1'b1;
      else if (id_adv)  id_valid <= 1'b0;
      if (in_fire && !flush) begin
        id_pc   <= in_pc;
        id_inst <= in_inst;
      end
    end
  end

  // Combinational decode of the latched instruction.
  always_comb begin
    ctl      = '0;
    imm      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OPC_LUI: begin
        ctl.rd_we = 1'b1; ctl.alu_op = ALU_PASS_B; ctl.src2_imm = 1'b1; imm = imm_u;
      end
      OPC_AUIPC: begin
        ctl.rd_we = 1'b1; ctl.src1_pc = 1'b1; ctl.src2_imm = 1'b1; imm = imm_u;
      end
      OPC_JAL: begin
        ctl.rd_we = 1'b1; ctl.jal = 1'b1; ctl.src1_pc = 1'b1; imm = imm_j;
      end
      OPC_JALR: begin
        ctl.rd_we = 1'b1; ctl.jalr = 1'b1; ctl.src2_imm = 1'b1; uses_rs1 = 1'b1; imm = imm_i;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        ctl.alu_op = ALU_SUB; ctl.br = br_from_funct3(f3); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm = imm_b; legal = (ctl.br != BR_NONE);
      end
      OPC_LOAD: begin
        ctl.rd_we = 1'b1; ctl.mem_re = 1'b1; ctl.src2_imm = 1'b1; uses_rs1 = 1'b1; imm = imm_i;
        ctl.mem_size = f3[1:0]; ctl.mem_uns = f3[2];
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
          3'b011, 3'b110:                         legal = IS_RV64;
          default:                                legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        ctl.mem_we = 1'b1; ctl.src2_imm = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_s;
        ctl.mem_size = f3[1:0];
        legal = (f3[2] == 1'b0) && ((f3[1:0] != MEM_SIZE_D) || IS_RV64);
      end
      OPC_OP_IMM: begin
        ctl.rd_we = 1'b1; ctl.src2_imm = 1'b1; uses_rs1 = 1'b1; imm = imm_i;
        case (f3)
          3'b000: ctl.alu_op = ALU_ADD;
          3'b010: ctl.alu_op = ALU_SLT;
          3'b011: ctl.alu_op = ALU_SLTU;
          3'b100: ctl.alu_op = ALU_XOR;
          3'b110: ctl.alu_op = ALU_OR;
          3'b111: ctl.alu_op = ALU_AND;
          3'b001: begin
            ctl.alu_op = ALU_SLL;
            legal = (id_inst[31:26] == 6'b000000) && shamt_ok;
          end
          default: begin
            ctl.alu_op = id_inst[30] ? ALU_SRA : ALU_SRL;
            legal = ((id_inst[31:26] == 6'b000000) || (id_inst[31:26] == 6'b010000)) && shamt_ok;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        ctl.rd_we = 1'b1; ctl.word = 1'b1; ctl.src2_imm = 1'b1; uses_rs1 = 1'b1; imm = imm_i;
        case (f3)
          3'b000:  ctl.alu_op = ALU_ADD;
          3'b001:  begin ctl.alu_op = ALU_SLL; legal = (f7 == 7'b0000000); end
          3'b101:  begin
            ctl.alu_op = id_inst[30] ? ALU_SRA : ALU_SRL;
            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          end
          default: legal = 1'b0;
        endcase
        if (!IS_RV64) legal = 1'b0;
      end
      OPC_OP, OPC_OP_32: begin
        ctl.rd_we = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctl.word = (opcode == OPC_OP_32);
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  ctl.alu_op = ALU_ADD;
            3'b001:  ctl.alu_op = ALU_SLL;
            3'b010:  ctl.alu_op = ALU_SLT;
            3'b011:  ctl.alu_op = ALU_SLTU;
            3'b100:  ctl.alu_op = ALU_XOR;
            3'b101:  ctl.alu_op = ALU_SRL;
            3'b110:  ctl.alu_op = ALU_OR;
            default: ctl.alu_op = ALU_AND;
          endcase
          if (ctl.word) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          ctl.alu_op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          ctl.alu_op = ALU_SRA;
        end else if (f7 == 7'b0000001 && HAS_M) begin
          case (f3)
            3'b000:  ctl.alu_op = ALU_MUL;
            3'b001:  ctl.alu_op = ALU_MULH;
            3'b010:  ctl.alu_op = ALU_MULHSU;
            3'b011:  ctl.alu_op = ALU_MULHU;
            3'b100:  ctl.alu_op = ALU_DIV;
            3'b101:  ctl.alu_op = ALU_DIVU;
            3'b110:  ctl.alu_op = ALU_REM;
            default: ctl.alu_op = ALU_REMU;
          endcase
          // The *W multiply group has no high-half variants.
          if (ctl.word) legal = (f3 == 3'b000) || f3[2];
        end else begin
          legal = 1'b0;
        end
        if (ctl.word && !IS_RV64) legal = 1'b0;
      end
      OPC_MISC_MEM: legal = (f3 == 3'b000);
      OPC_SYSTEM: begin
        if (id_inst == EBREAK_INST) ctl.ebreak = 1'b1;
        else                        legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    // Illegal instructions write nothing and read nothing, so they never stall.
    if (!legal) begin
      ctl         = '0;
      ctl.illegal = 1'b1;
      uses_rs1    = 1'b0;
      uses_rs2    = 1'b0;
    end
  end

  // ID/EX register: capture on issue, hold while EXU stalls, drop on flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      ctl_q        <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (id_adv)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (issue) begin
        out_pc       <= id_pc;
        out_imm      <= imm;
        out_rs1_data <= rf_rdata1;
        out_rs2_data <= rf_rdata2;
        out_rd       <= id_inst[11:7];
        ctl_q        <= ctl;
      end
    end
  end

  assign out_rd_we    = ctl_q.rd_we;
  assign out_alu_op   = ctl_q.alu_op;
  assign out_src1_pc  = ctl_q.src1_pc;
  assign out_src2_imm = ctl_q.src2_imm;
  assign out_word     = ctl_q.word;
  assign out_mem_re   = ctl_q.mem_re;
  assign out_mem_we   = ctl_q.mem_we;
  assign out_mem_size = ctl_q.mem_size;
  assign out_mem_uns  = ctl_q.mem_uns;
  assign out_br       = ctl_q.br;
  assign out_jal      = ctl_q.jal;
  assign out_jalr     = ctl_q.jalr;
  assign out_ebreak   = ctl_q.ebreak;
  assign out_illegal  = ctl_q.illegal;

  rv_idu_scoreboard u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (issue & ctl.rd_we & (id_inst[11:7] != 5'd0)),
    .set_rd (id_inst[11:7]),
    .clr_en (wb_valid),
    .clr_rd (wb_rd),
    .rs1    (id_inst[19:15]),
    .rs2    (id_inst[24:20]),
    .busy1  (busy1),
    .busy2  (busy2)
  );

endmodule
